// File: rtl/hd_block_writer_if.sv
// ----------------------------------------------------------------------------
// hd_block_writer_if
//   Bundles the request, RAM read and HD write signals of the block writer.
//   slave  : the block writer itself (takes requests and RAM data, drives the
//            RAM read port, the HD write port and status).
//   master : the environment (requester plus RAM and HD models).
//
//   start/block_num/ram_base/length : save request
//   ram_addr/ram_re/ram_data        : synchronous RAM read port
//   hd_addr/hd_wdata/hd_we          : HD write port
//   busy/done/error                 : status
// ----------------------------------------------------------------------------
interface hd_block_writer_if;
    logic        start;
    logic [31:0] block_num;
    logic [31:0] ram_base;
    logic [31:0] length;
    logic [31:0] ram_addr;
    logic        ram_re;
    logic [31:0] ram_data;
    logic [31:0] hd_addr;
    logic [31:0] hd_wdata;
    logic        hd_we;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, block_num, ram_base, length, ram_data,
        input  ram_addr, ram_re, hd_addr, hd_wdata, hd_we, busy, done, error
    );

    modport slave (
        input  start, block_num, ram_base, length, ram_data,
        output ram_addr, ram_re, hd_addr, hd_wdata, hd_we, busy, done, error
    );
endinterface

// File: rtl/hd_block_writer.sv
// ----------------------------------------------------------------------------
// hd_block_writer
//   Swap-out engine: copies a process image from RAM into its fixed-size HD
//   block. Writes a one-word length header at the block base, then streams the
//   payload to the following HD lines with no gaps.
//
// Ports:
//   clk    : clock, all state changes on posedge
//   reset  : asynchronous, active-high; returns to IDLE with all outputs 0
//   bus    : hd_block_writer_if.slave (request, RAM read port, HD write port,
//            busy/done/error status)
//
// Parameters:
//   BLOCK_SIZE : HD words per block (header + up to BLOCK_SIZE-1 payload words)
//   HD_DEPTH   : HD words in total; HD_DEPTH/BLOCK_SIZE blocks
// ----------------------------------------------------------------------------
module hd_block_writer #(
    parameter int BLOCK_SIZE = 200,
    parameter int HD_DEPTH   = 4000
) (
    input  logic               clk,
    input  logic               reset,
    hd_block_writer_if.slave   bus
);

    localparam int          NB      = HD_DEPTH / BLOCK_SIZE;
    localparam logic [31:0] NB_W    = 32'(NB);
    localparam logic [31:0] BS_W    = 32'(BLOCK_SIZE);
    localparam logic [31:0] MAX_LEN = 32'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PRIME,
        COPY,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] len_r;   // captured payload length L
    logic [31:0] wcnt;    // index k of the payload word currently on the HD port

    // A request fits when the block exists and the payload fits behind the header.
    function automatic logic req_ok(input logic [31:0] bn, input logic [31:0] len);
        return (bn < NB_W) && (len != 32'd0) && (len <= MAX_LEN);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len_r        <= 32'd0;
            wcnt         <= 32'd0;
            bus.ram_addr <= 32'd0;
            bus.ram_re   <= 1'b0;
            bus.hd_addr  <= 32'd0;
            bus.hd_wdata <= 32'd0;
            bus.hd_we    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;

            case (state)
                // DONE behaves like IDLE for request sampling so that a start
                // in the done cycle is taken without an extra gap.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
                        if (req_ok(bus.block_num, bus.length)) begin
                            state        <= HEADER;
                            len_r        <= bus.length;
                            bus.hd_we    <= 1'b1;
                            bus.hd_addr  <= bus.block_num * BS_W;
                            bus.hd_wdata <= bus.length;
                            bus.ram_re   <= 1'b1;
                            bus.ram_addr <= bus.ram_base;
                            bus.busy     <= 1'b1;
                        end else begin
                            bus.error <= 1'b1;
                        end
                    end
                end

                // Header is on the HD port; read 0 is in flight. Issue read 1.
                HEADER: begin
                    state     <= PRIME;
                    bus.hd_we <= 1'b0;
                    if (len_r > 32'd1) begin
                        bus.ram_re   <= 1'b1;
                        bus.ram_addr <= bus.ram_addr + 32'd1;
                    end else begin
                        bus.ram_re <= 1'b0;
                    end
                end

                // Read 0 data is now on ram_data: write payload word 0, issue read 2.
                PRIME: begin
                    state        <= COPY;
                    wcnt         <= 32'd0;
                    bus.hd_we    <= 1'b1;
                    bus.hd_addr  <= bus.hd_addr + 32'd1;
                    bus.hd_wdata <= bus.ram_data;
                    if (len_r > 32'd2) begin
                        bus.ram_re   <= 1'b1;
                        bus.ram_addr <= bus.ram_addr + 32'd1;
                    end else begin
                        bus.ram_re <= 1'b0;
                    end
                end

                // Reads run two words ahead of writes; stop issuing at word L-1.
                COPY: begin
                    if (wcnt == len_r - 32'd1) begin
                        state      <= DONE;
                        bus.hd_we  <= 1'b0;
                        bus.ram_re <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end else begin
                        wcnt         <= wcnt + 32'd1;
                        bus.hd_addr  <= bus.hd_addr + 32'd1;
                        bus.hd_wdata <= bus.ram_data;
                        if (wcnt + 32'd3 < len_r) begin
                            bus.ram_re   <= 1'b1;
                            bus.ram_addr <= bus.ram_addr + 32'd1;
                        end else begin
                            bus.ram_re <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_block_writer.sv
// ----------------------------------------------------------------------------
// tb_hd_block_writer
//   Self-checking bench for hd_block_writer. A synchronous RAM model feeds the
//   DUT; every HD write is popped from a queue of expected (addr, data) pairs
//   pushed when a request is driven. Scenario tasks check latency, write and
//   read counts, rejects, reset and back-to-back behaviour.
// ----------------------------------------------------------------------------
module tb_hd_block_writer;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hd_block_writer_if bus();

    hd_block_writer #(.BLOCK_SIZE(200), .HD_DEPTH(4000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [63:0] exp_q [$];
    logic [31:0] rd_lo = 32'd0;
    logic [31:0] rd_hi = 32'd0;
    int total = 0;
    int bad   = 0;

    // Synchronous RAM: data one cycle after the address/enable edge.
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_data <= mem[bus.ram_addr[11:0]];
    end

    // Scoreboard: every HD write must be the next expected one and in range;
    // every RAM read must lie inside the current image.
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.hd_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL hd_write_unexpected got addr=%0d data=%h, required no write",
                         bus.hd_addr, bus.hd_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.hd_addr, bus.hd_wdata} !== e) begin
                    bad++;
                    $display("FAIL hd_write got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.hd_addr, bus.hd_wdata, e[63:32], e[31:0]);
                end
            end
            total++;
            if (bus.hd_addr >= 32'd4000) begin
                bad++;
                $display("FAIL hd_range got addr=%0d, required < 4000", bus.hd_addr);
            end
        end
        if (bus.ram_re) begin
            total++;
            if (bus.ram_addr < rd_lo || bus.ram_addr > rd_hi) begin
                bad++;
                $display("FAIL ram_range got addr=%0d, required %0d..%0d",
                         bus.ram_addr, rd_lo, rd_hi);
            end
        end
    end

    // Drives one save at the current negedge and follows it to done.
    // Cycle index i is the negedge after edge T0+i.
    task automatic run_save(input logic [31:0] bn, input logic [31:0] base,
                            input logic [31:0] len, input int poke_idx,
                            output int done_idx, output int we_cnt, output int rd_cnt,
                            output logic busy_ok, output logic bubble_we,
                            output logic hdr_ok);
        logic [31:0] hb;
        logic [31:0] a;
        int lim;
        hb = bn * 32'd200;
        exp_q.push_back({hb, len});
        for (int k = 0; k < int'(len); k++) begin
            a = base + 32'(k);
            exp_q.push_back({hb + 32'd1 + 32'(k), mem[a[11:0]]});
        end
        rd_lo = base;
        rd_hi = base + len - 32'd1;
        bus.block_num = bn;
        bus.ram_base  = base;
        bus.length    = len;
        bus.start     = 1'b1;
        @(posedge clk);
        done_idx = -1; we_cnt = 0; rd_cnt = 0;
        busy_ok = 1'b1; bubble_we = 1'b1; hdr_ok = 1'b0;
        lim = int'(len) + 12;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (i == poke_idx) begin
                bus.start = 1'b1; bus.block_num = 32'd5;
                bus.ram_base = 32'd100; bus.length = 32'd7;
            end else if (i == poke_idx + 1) begin
                bus.start = 1'b0;
            end
            if (i == 0) hdr_ok = bus.hd_we && (bus.hd_addr == hb) && bus.busy;
            if (i == 1) bubble_we = bus.hd_we;
            if (bus.hd_we) we_cnt++;
            if (bus.ram_re) rd_cnt++;
            if (bus.done) begin
                done_idx = i;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.block_num = 32'd0; bus.ram_base = 32'd0; bus.length = 32'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.ram_addr, bus.ram_re, bus.hd_addr, bus.hd_wdata, bus.hd_we,
             bus.busy, bus.done, bus.error} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ram_addr=%0d ram_re=%b hd_addr=%0d hd_wdata=%h hd_we=%b busy=%b done=%b error=%b, required all 0",
                     bus.ram_addr, bus.ram_re, bus.hd_addr, bus.hd_wdata, bus.hd_we,
                     bus.busy, bus.done, bus.error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int d, w, r; logic bo, bw, ho;
        mem[16] = 32'hA; mem[17] = 32'hB; mem[18] = 32'hC;
        run_save(32'd2, 32'd16, 32'd3, -1, d, w, r, bo, bw, ho);
        total++; if (d !== 5) begin bad++; $display("FAIL nominal_done_idx got %0d required 5", d); end
        total++; if (w !== 4) begin bad++; $display("FAIL nominal_we_cycles got %0d required 4", w); end
        total++; if (r !== 3) begin bad++; $display("FAIL nominal_reads got %0d required 3", r); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL nominal_busy got %b required 1", bo); end
        total++; if (bw !== 1'b0) begin bad++; $display("FAIL nominal_bubble got hd_we=%b required 0", bw); end
        total++; if (ho !== 1'b1) begin bad++; $display("FAIL nominal_header got %b required 1", ho); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL nominal_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_len_one();
        int d, w, r; logic bo, bw, ho;
        mem[40] = 32'h1234_5678;
        run_save(32'd0, 32'd40, 32'd1, -1, d, w, r, bo, bw, ho);
        total++; if (d !== 3) begin bad++; $display("FAIL len1_done_idx got %0d required 3", d); end
        total++; if (w !== 2) begin bad++; $display("FAIL len1_we_cycles got %0d required 2", w); end
        total++; if (r !== 1) begin bad++; $display("FAIL len1_reads got %0d required 1", r); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL len1_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_len_max();
        int d, w, r; logic bo, bw, ho;
        run_save(32'd19, 32'd500, 32'd199, -1, d, w, r, bo, bw, ho);
        total++; if (d !== 201) begin bad++; $display("FAIL lenmax_done_idx got %0d required 201", d); end
        total++; if (w !== 200) begin bad++; $display("FAIL lenmax_we_cycles got %0d required 200", w); end
        total++; if (r !== 199) begin bad++; $display("FAIL lenmax_reads got %0d required 199", r); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL lenmax_busy got %b required 1", bo); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL lenmax_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reject();
        logic [31:0] bns  [3] = '{32'd20, 32'd3, 32'd3};
        logic [31:0] lens [3] = '{32'd5,  32'd0, 32'd200};
        for (int c = 0; c < 3; c++) begin
            bus.block_num = bns[c];
            bus.ram_base  = 32'd8;
            bus.length    = lens[c];
            bus.start     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            total++;
            if ({bus.error, bus.busy, bus.hd_we} !== 3'b100) begin
                bad++;
                $display("FAIL reject%0d_pulse got error=%b busy=%b hd_we=%b, required 1 0 0",
                         c, bus.error, bus.busy, bus.hd_we);
            end
            @(negedge clk);
            total++;
            if ({bus.error, bus.busy, bus.hd_we} !== 3'b000) begin
                bad++;
                $display("FAIL reject%0d_after got error=%b busy=%b hd_we=%b, required 0 0 0",
                         c, bus.error, bus.busy, bus.hd_we);
            end
        end
    endtask

    task automatic test_ignore_mid();
        int d, w, r; logic bo, bw, ho;
        run_save(32'd4, 32'd200, 32'd6, 3, d, w, r, bo, bw, ho);
        total++; if (d !== 8) begin bad++; $display("FAIL ignore_done_idx got %0d required 8", d); end
        total++; if (w !== 7) begin bad++; $display("FAIL ignore_we_cycles got %0d required 7", w); end
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_restart got busy=%b required 0", bus.busy); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ignore_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d, w, r; logic bo, bw, ho;
        logic [31:0] hb;
        hb = 32'd3 * 32'd200;
        exp_q.push_back({hb, 32'd5});
        exp_q.push_back({hb + 32'd1, mem[900]});
        exp_q.push_back({hb + 32'd2, mem[901]});
        rd_lo = 32'd900; rd_hi = 32'd904;
        bus.block_num = 32'd3; bus.ram_base = 32'd900; bus.length = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.ram_addr, bus.ram_re, bus.hd_addr, bus.hd_wdata, bus.hd_we,
             bus.busy, bus.done, bus.error} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got ram_re=%b hd_we=%b busy=%b hd_addr=%0d, required all 0",
                     bus.ram_re, bus.hd_we, bus.busy, bus.hd_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy, bus.hd_we} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_idle got done=%b busy=%b hd_we=%b, required 0 0 0",
                     bus.done, bus.busy, bus.hd_we);
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL midreset_pending got %0d required 0", exp_q.size()); end
        run_save(32'd1, 32'd300, 32'd4, -1, d, w, r, bo, bw, ho);
        total++; if (d !== 6) begin bad++; $display("FAIL postreset_done_idx got %0d required 6", d); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL postreset_pending got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d, w, r; logic bo, bw, ho;
        run_save(32'd6, 32'd600, 32'd2, -1, d, w, r, bo, bw, ho);
        total++; if (d !== 4) begin bad++; $display("FAIL b2b_first_done_idx got %0d required 4", d); end
        // Still in the done cycle: the next request goes in right away.
        run_save(32'd7, 32'd700, 32'd3, -1, d, w, r, bo, bw, ho);
        total++; if (ho !== 1'b1) begin bad++; $display("FAIL b2b_header got %b required 1", ho); end
        total++; if (d !== 5) begin bad++; $display("FAIL b2b_second_done_idx got %0d required 5", d); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_pending got %0d required 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        bus.ram_data = 32'd0;
        test_reset();
        test_nominal();
        test_len_one();
        test_len_max();
        test_reject();
        test_ignore_mid();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
